// File: rtl/ik_swift_qsys_st_packet_arbiter_if.sv
// ik_swift_qsys_st_packet_arbiter_if: requester-side and channelized source-side Avalon-ST signals
interface ik_swift_qsys_st_packet_arbiter_if #(
  parameter int NUM_IN = 4,
  parameter int DATA_W = 8
);
  logic [NUM_IN-1:0] in_valid;
  logic [NUM_IN-1:0] in_ready;
  logic [NUM_IN-1:0] in_startofpacket;
  logic [NUM_IN-1:0] in_endofpacket;
  logic [NUM_IN*DATA_W-1:0] in_data;
  logic out_ready;
  logic out_valid;
  logic out_startofpacket;
  logic out_endofpacket;
  logic [DATA_W-1:0] out_data;
  logic [7:0] out_channel;
  modport master (
    output in_valid, in_data, in_startofpacket, in_endofpacket, out_ready,
    input in_ready, out_valid, out_data, out_channel, out_startofpacket, out_endofpacket
  );
  modport slave (
    input in_valid, in_data, in_startofpacket, in_endofpacket, out_ready,
    output in_ready, out_valid, out_data, out_channel, out_startofpacket, out_endofpacket
  );
endinterface

// File: rtl/ik_swift_qsys_st_packet_arbiter.sv
// ik_swift_qsys_st_packet_arbiter: round-robin packet-locking arbiter onto a channelized Avalon-ST source
module ik_swift_qsys_st_packet_arbiter #(
  parameter int NUM_IN = 4,
  parameter int DATA_W = 8
) (
  input  logic clk,
  input  logic reset,
  ik_swift_qsys_st_packet_arbiter_if.slave bus,
  input  logic [NUM_IN-1:0] enable_mask,
  output logic busy,
  output logic [2:0] grant_id,
  output logic [7:0] err_count
);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state;
  logic [NUM_IN-1:0] req, drop, sel;
  logic [2:0] pick;
  logic [8:0] err_sum;
  logic load, in_sop, in_eop;
  logic [DATA_W-1:0] in_beat;
  // requests, discards, round-robin pick starting after the last grant, and the granted beat mux
  always_comb begin
    req = bus.in_valid & bus.in_startofpacket & enable_mask;
    drop = (state == IDLE) ? bus.in_valid & ~bus.in_startofpacket & enable_mask : '0;
    pick = grant_id;
    for (int k = NUM_IN; k >= 1; k--)
      if (|(req & (NUM_IN'(1) << ((int'(grant_id) + k) % NUM_IN))))
        pick = 3'((int'(grant_id) + k) % NUM_IN);
    err_sum = {1'b0, err_count} + 9'($countones(drop));
    sel = NUM_IN'(1) << grant_id;
    in_beat = DATA_W'(bus.in_data >> (grant_id * DATA_W));
    in_sop = |(sel & bus.in_startofpacket);
    in_eop = |(sel & bus.in_endofpacket);
    load = (state == LOCKED) && |(sel & bus.in_valid) && (!bus.out_valid || bus.out_ready);
    bus.in_ready = reset ? '0 : (state == LOCKED) ? sel & {NUM_IN{!bus.out_valid || bus.out_ready}} : drop;
    busy = (state == LOCKED);
  end
  // FSM, grant register, single output register stage and saturating discard counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      grant_id <= 3'(NUM_IN - 1);
      err_count <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data <= '0;
      bus.out_channel <= '0;
      bus.out_startofpacket <= 1'b0;
      bus.out_endofpacket <= 1'b0;
    end else begin
      err_count <= err_sum[8] ? 8'hff : err_sum[7:0];
      if (state == IDLE && |req) begin
        state <= LOCKED;
        grant_id <= pick;
      end else if (load && in_eop) begin
        state <= IDLE;
      end
      bus.out_valid <= load || (bus.out_valid && !bus.out_ready);
      if (load) begin
        bus.out_data <= in_beat;
        bus.out_channel <= {5'b0, grant_id};
        bus.out_startofpacket <= in_sop;
        bus.out_endofpacket <= in_eop;
      end
    end
  end
endmodule

// File: tb/tb_ik_swift_qsys_st_packet_arbiter.sv
// tb_ik_swift_qsys_st_packet_arbiter: directed scoreboard bench for the packet arbiter
module tb_ik_swift_qsys_st_packet_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  typedef struct packed {logic [7:0] d; logic sop; logic eop;} beat_t;
  typedef struct packed {logic [7:0] ch; logic [7:0] d; logic sop; logic eop;} exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] enable_mask = '1;
  logic busy;
  logic [2:0] grant_id;
  logic [7:0] err_count;
  ik_swift_qsys_st_packet_arbiter_if #(.NUM_IN(N), .DATA_W(W)) bus();
  ik_swift_qsys_st_packet_arbiter #(.NUM_IN(N), .DATA_W(W)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave), .enable_mask(enable_mask),
    .busy(busy), .grant_id(grant_id), .err_count(err_count)
  );
  always #5 clk = ~clk;
  beat_t src_q[N][$];
  exp_t exp_q[$];
  int stamps[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int stall_cnt = 0;
  logic or_mode = 1'b0;
  logic [3:0] pat = 4'b1001;
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.in_valid[i] = src_q[i].size() > 0;
      bus.in_data[i*W +: W] = (src_q[i].size() > 0) ? src_q[i][0].d : '0;
      bus.in_startofpacket[i] = (src_q[i].size() > 0) ? src_q[i][0].sop : 1'b0;
      bus.in_endofpacket[i] = (src_q[i].size() > 0) ? src_q[i][0].eop : 1'b0;
    end
    bus.out_ready = or_mode ? pat[2'(cyc)] : 1'b1;
  endtask

  task automatic check_out();
    exp_t e;
    chk("beat_expected", exp_q.size() > 0, 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("out_channel", bus.out_channel, e.ch);
      chk("out_data", bus.out_data, e.d);
      chk("out_sop", bus.out_startofpacket, e.sop);
      chk("out_eop", bus.out_endofpacket, e.eop);
      if (!e.eop) chk("busy_in_packet", busy, 1);
    end
    stamps.push_back(cyc);
  endtask

  task automatic cycle();
    logic [N-1:0] fire;
    @(negedge clk);
    fire = bus.in_valid & bus.in_ready;
    if (prev_stall) begin
      stall_cnt++;
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_data", bus.out_data, prev_data);
    end
    if (busy && bus.out_valid && !bus.out_ready) chk("stall_in_ready", bus.in_ready, 0);
    prev_stall = bus.out_valid && !bus.out_ready;
    prev_data = bus.out_data;
    if (bus.out_valid && bus.out_ready) check_out();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) if (fire[i]) void'(src_q[i].pop_front());
    drive();
  endtask

  task automatic drain(input int max);
    int n = 0;
    while (exp_q.size() > 0 && n < max) begin
      cycle();
      n++;
    end
    chk("drain_in_budget", n < max, 1);
  endtask

  task automatic clear_all();
    for (int i = 0; i < N; i++) src_q[i].delete();
    exp_q.delete();
    prev_stall = 1'b0;
    drive();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_all();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = '1;
    bus.in_startofpacket = '0;
    bus.in_endofpacket = '0;
    bus.in_data = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant_id", grant_id, N - 1);
    chk("rst_err_count", err_count, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_channel", bus.out_channel, 0);
    reset = 1'b0;
    clear_all();
    // two 3-beat packets on requesters 0 and 2
    for (int b = 0; b < 3; b++) begin
      src_q[0].push_back({8'(8'h01 + b), b == 0, b == 2});
      src_q[2].push_back({8'(8'h21 + b), b == 0, b == 2});
    end
    for (int b = 0; b < 3; b++) exp_q.push_back({8'd0, 8'(8'h01 + b), b == 0, b == 2});
    for (int b = 0; b < 3; b++) exp_q.push_back({8'd2, 8'(8'h21 + b), b == 0, b == 2});
    stamps.delete();
    drive();
    drain(40);
    chk("b2b_throughput", 32'(stamps[1] - stamps[0]), 1);
    chk("gap_between_packets", 32'(stamps[3] - stamps[2]), 2);
    chk("idle_after_pair", busy, 0);
    chk("last_grant", grant_id, 2);
    // four requesters with back-to-back single-beat packets
    do_reset();
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < N; i++) begin
        src_q[i].push_back({8'(8'h40 + 16 * i + p), 1'b1, 1'b1});
        exp_q.push_back({8'(i), 8'(8'h40 + 16 * i + p), 1'b1, 1'b1});
      end
    drive();
    drain(60);
    // 4-beat packet on requester 1 with out_ready pattern 1,0,0,1
    do_reset();
    or_mode = 1'b1;
    stall_cnt = 0;
    for (int b = 0; b < 4; b++) begin
      src_q[1].push_back({8'(8'hA0 + b), b == 0, b == 3});
      exp_q.push_back({8'd1, 8'(8'hA0 + b), b == 0, b == 3});
    end
    drive();
    drain(60);
    or_mode = 1'b0;
    chk("stalls_exercised", stall_cnt > 0, 1);
    // 300 non-SOP beats on requester 3 while idle
    for (int b = 0; b < 300; b++) src_q[3].push_back({8'(b), 1'b0, 1'b0});
    drive();
    repeat (5) cycle();
    chk("err_partial", err_count, 5);
    begin
      int n = 0;
      while (src_q[3].size() > 0 && n < 400) begin
        cycle();
        n++;
      end
      chk("drops_in_budget", n < 400, 1);
    end
    chk("err_saturated", err_count, 255);
    chk("idle_during_drops", busy, 0);
    // reset in the middle of a 5-beat packet
    for (int b = 0; b < 5; b++) src_q[1].push_back({8'(8'hB0 + b), b == 0, b == 4});
    exp_q.push_back({8'd1, 8'hB0, 1'b1, 1'b0});
    drive();
    repeat (3) cycle();
    chk("pre_reset_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_grant_id", grant_id, N - 1);
    chk("mid_rst_err_count", err_count, 0);
    chk("mid_rst_in_ready", bus.in_ready, 0);
    chk("mid_rst_out_eop", bus.out_endofpacket, 0);
    chk("mid_rst_out_data", bus.out_data, 0);
    clear_all();
    @(posedge clk);
    #1;
    reset = 1'b0;
    src_q[1].push_back({8'hC0, 1'b1, 1'b0});
    src_q[1].push_back({8'hC1, 1'b0, 1'b1});
    src_q[0].push_back({8'hD0, 1'b1, 1'b1});
    exp_q.push_back({8'd0, 8'hD0, 1'b1, 1'b1});
    exp_q.push_back({8'd1, 8'hC0, 1'b1, 1'b0});
    exp_q.push_back({8'd1, 8'hC1, 1'b0, 1'b1});
    drive();
    drain(40);
    // enable_mask[1] dropped mid-packet
    for (int b = 0; b < 3; b++) begin
      src_q[1].push_back({8'(8'hE0 + b), b == 0, b == 2});
      exp_q.push_back({8'd1, 8'(8'hE0 + b), b == 0, b == 2});
    end
    src_q[1].push_back({8'hF0, 1'b1, 1'b1});
    drive();
    repeat (2) cycle();
    enable_mask[1] = 1'b0;
    drain(40);
    repeat (5) cycle();
    chk("masked_not_granted", busy, 0);
    chk("masked_sop_pending", src_q[1].size(), 1);
    chk("masked_grant_id", grant_id, 1);
    src_q[2].push_back({8'h60, 1'b1, 1'b1});
    exp_q.push_back({8'd2, 8'h60, 1'b1, 1'b1});
    drive();
    drain(40);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
